// File: rtl/fifo_uart_tx_pkg.sv
// Shared constants for the FIFO-drain UART transmitter: FSM encoding and frame geometry.
// State values are fixed so that the debug state output reads the same across revisions.
package fifo_uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_POP    = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_START  = 3'd3;
   localparam logic [2:0] ST_DATA   = 3'd4;
   localparam logic [2:0] ST_PARITY = 3'd5;
   localparam logic [2:0] ST_STOP   = 3'd6;

   localparam int UART_DATA_BITS = 8;

   // Parity line level from the XOR of the data bits; odd parity inverts it.
   function automatic logic parity_level(input logic data_xor, input logic odd);
      return data_xor ^ odd;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read side of the 16x8 byte FIFO as seen by the UART drain stage.
// Handshake: the drain pulses fifo_read_en for one cycle only while fifo_empty is low;
// fifo_data holds the popped byte from the cycle after that pulse onward.
interface fifo_uart_tx_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read_en;

   modport master (input fifo_empty, input fifo_data, output fifo_read_en);
   modport slave  (output fifo_empty, output fifo_data, input fifo_read_en);
endinterface

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// A clear restarts the period so every FSM state begins on a full bit.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] count_q;

   assign tick = (count_q == LAST_COUNT);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clear || tick) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + 16'd1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO onto a UART TX line: start, 8 data bits LSB first, optional parity, stop.
// One pop per frame; the popped byte is captured as the start bit begins.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   fifo_uart_tx_if.master        fifo,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done,
   output logic [15:0]           frame_count,
   output logic [2:0]            state_dbg
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic [2:0]  state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic        par_q, par_d;
   logic [2:0]  bit_q, bit_d;
   logic [15:0] frame_count_q;
   logic        tx_q, tx_d;
   logic        tick;
   logic        clear;

   assign clear = (state_d != state_q);

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      par_d   = par_q;
      bit_d   = bit_q;
      case (state_q)
         ST_IDLE:   if (!fifo.fifo_empty) state_d = ST_POP;
         ST_POP:    state_d = ST_LOAD;
         // Leaving LOAD is the start-bit entry: the FIFO output is valid now.
         ST_LOAD: begin
            state_d = ST_START;
            shift_d = fifo.fifo_data;
            par_d   = 1'b0;
            bit_d   = '0;
         end
         ST_START:  if (tick) state_d = ST_DATA;
         ST_DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[7:1]};
               par_d   = par_q ^ shift_q[0];
               bit_d   = bit_q + 3'd1;
               if (bit_q == LAST_BIT) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: if (tick) state_d = ST_STOP;
         ST_STOP:   if (tick) state_d = fifo.fifo_empty ? ST_IDLE : ST_POP;
         default:   state_d = ST_IDLE;
      endcase
   end

   // tx is computed from the next state so the pin itself is a flop.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = parity_level(par_d, PARITY_ODD);
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         shift_q       <= '0;
         par_q         <= 1'b0;
         bit_q         <= '0;
         tx_q          <= 1'b1;
         frame_count_q <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         if (tx_done) frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign fifo.fifo_read_en = (state_q == ST_POP);
   assign tx_done           = (state_q == ST_STOP) && tick;
   assign busy              = (state_q != ST_IDLE);
   assign tx                = tx_q;
   assign frame_count       = frame_count_q;
   assign state_dbg         = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: one plain instance plus even- and odd-parity instances, all at 4 clocks/bit.
// Bytes are pushed into FIFO models and into the expected queue; captured frames are popped and compared.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  localparam int CPB = 4;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fifo_uart_tx_if if0 ();
  fifo_uart_tx_if if1 ();
  fifo_uart_tx_if if2 ();

  logic        tx0, tx1, tx2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [15:0] fc0, fc1, fc2;
  logic [2:0]  st0, st1, st2;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
    .clock(clock), .reset(reset), .fifo(if0.master), .tx(tx0), .busy(busy0),
    .tx_done(done0), .frame_count(fc0), .state_dbg(st0));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_even (
    .clock(clock), .reset(reset), .fifo(if1.master), .tx(tx1), .busy(busy1),
    .tx_done(done1), .frame_count(fc1), .state_dbg(st1));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_odd (
    .clock(clock), .reset(reset), .fifo(if2.master), .tx(tx2), .busy(busy2),
    .tx_done(done2), .frame_count(fc2), .state_dbg(st2));

  // FIFO models: registered dataout, valid the cycle after read_en
  logic [7:0] mem0 [0:63];
  int push0 = 0, pop0 = 0;
  int push1 = 0, pop1 = 0;
  int push2 = 0, pop2 = 0;

  assign if0.fifo_empty = (pop0 == push0);
  assign if1.fifo_empty = (pop1 == push1);
  assign if2.fifo_empty = (pop2 == push2);

  always @(posedge clock) if (if0.fifo_read_en) begin
    if0.fifo_data <= mem0[pop0 & 63];
    pop0 <= pop0 + 1;
  end
  always @(posedge clock) if (if1.fifo_read_en) begin
    if1.fifo_data <= 8'h07;
    pop1 <= pop1 + 1;
  end
  always @(posedge clock) if (if2.fifo_read_en) begin
    if2.fifo_data <= 8'h07;
    pop2 <= pop2 + 1;
  end

  // read-strobe bookkeeping
  int rd0 = 0;
  int pop_viol = 0;
  always @(negedge clock) begin
    if (if0.fifo_read_en) rd0 <= rd0 + 1;
    if ((if0.fifo_read_en && if0.fifo_empty) || (if1.fifo_read_en && if1.fifo_empty) ||
        (if2.fifo_read_en && if2.fifo_empty))
      pop_viol <= pop_viol + 1;
  end

  // scoreboard
  logic [7:0] exp_q [$];
  logic [15:0] exp_frames = 16'd0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push_byte(input logic [7:0] b);
    mem0[push0 & 63] = b;
    push0 = push0 + 1;
    exp_q.push_back(b);
  endtask

  function automatic logic tx_of(input int inst);
    case (inst)
      0: return tx0;
      1: return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic done_of(input int inst);
    case (inst)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  // Waits (bounded) for a start bit, then samples nbits bit periods at negedges.
  // gap = idle cycles between the call and the start bit, minus the call cycle.
  task automatic capture(input int inst, input int nbits, output logic [10:0] bits,
                         output int gap, output int done_cnt, output int done_off,
                         output int unstable);
    int w;
    logic first;
    bits = '0; gap = 0; done_cnt = 0; done_off = -1; unstable = 0; first = 1'b0;
    w = 0;
    while (tx_of(inst) !== 1'b0 && w < 2000) begin
      @(negedge clock);
      w++;
    end
    check_eq("start_seen", (w < 2000), 1);
    if (w >= 2000) return;
    gap = w - 1;
    for (int off = 0; off < nbits * CPB; off++) begin
      if (off > 0) @(negedge clock);
      if (off % CPB == 0) first = tx_of(inst);
      else if (tx_of(inst) !== first) unstable++;
      if (off % CPB == 1) bits[off / CPB] = tx_of(inst);
      if (done_of(inst) === 1'b1) begin
        done_cnt++;
        done_off = off;
      end
    end
  endtask

  // Captures one plain frame from the main instance and scores it against the expected queue.
  task automatic score_frame(input string tag, output int gap);
    logic [10:0] bits;
    logic [7:0]  exp_b;
    int dc, doff, uns;
    capture(0, 10, bits, gap, dc, doff, uns);
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check_eq({tag, "_frame"}, {21'd0, bits}, {21'd0, 1'b0, 1'b1, exp_b, 1'b0});
    check_eq({tag, "_done_cnt"}, dc, 1);
    check_eq({tag, "_done_off"}, doff, 10 * CPB - 1);
    check_eq({tag, "_stable"}, uns, 0);
    exp_frames = exp_frames + 16'd1;
  endtask

  initial begin
    logic [10:0] bits;
    int gap, dc, doff, uns, rd_before, bad;
    int w;

    if0.fifo_data = 8'h00;
    if1.fifo_data = 8'h00;
    if2.fifo_data = 8'h00;

    // reset state
    repeat (3) @(negedge clock);
    check_eq("rst_tx", tx0, 1);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_read_en", if0.fifo_read_en, 0);
    check_eq("rst_tx_done", done0, 0);
    check_eq("rst_frame_count", fc0, 0);
    check_eq("rst_state", st0, ST_IDLE);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single byte 0xA5, no parity
    rd_before = rd0;
    push_byte(8'hA5);
    score_frame("t1", gap);
    @(negedge clock);
    check_eq("t1_frame_count", fc0, exp_frames);
    check_eq("t1_pops", rd0 - rd_before, 1);
    check_eq("t1_idle_state", st0, ST_IDLE);
    check_eq("t1_idle_busy", busy0, 0);

    // empty FIFO for 200 cycles
    rd_before = rd0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (if0.fifo_read_en !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
    end
    check_eq("t2_quiet_cycles", bad, 0);
    check_eq("t2_pops", rd0 - rd_before, 0);

    // three back-to-back bytes
    rd_before = rd0;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    score_frame("t3a", gap);
    score_frame("t3b", gap);
    check_eq("t3b_gap", gap, 2);
    score_frame("t3c", gap);
    check_eq("t3c_gap", gap, 2);
    @(negedge clock);
    check_eq("t3_frame_count", fc0, exp_frames);
    check_eq("t3_pops", rd0 - rd_before, 3);
    check_eq("t3_idle_state", st0, ST_IDLE);

    // parity: even then odd, byte 0x07
    push1 = push1 + 1;
    capture(1, 11, bits, gap, dc, doff, uns);
    check_eq("t4_even_frame", {21'd0, bits}, {21'd0, 1'b1, 1'b1, 8'h07, 1'b0});
    check_eq("t4_even_done_off", doff, 11 * CPB - 1);
    check_eq("t4_even_stable", uns, 0);
    @(negedge clock);
    check_eq("t4_even_frame_count", fc1, 1);
    push2 = push2 + 1;
    capture(2, 11, bits, gap, dc, doff, uns);
    check_eq("t4_odd_frame", {21'd0, bits}, {21'd0, 1'b1, 1'b0, 8'h07, 1'b0});
    check_eq("t4_odd_done_off", doff, 11 * CPB - 1);
    check_eq("t4_odd_done_cnt", dc, 1);

    // reset during data bit 3
    rd_before = rd0;
    push_byte(8'h3C);
    w = 0;
    while (tx0 !== 1'b0 && w < 2000) begin
      @(negedge clock);
      w++;
    end
    check_eq("t5_start_seen", (w < 2000), 1);
    repeat (4 * CPB + 1) @(negedge clock);
    check_eq("t5_in_data", st0, ST_DATA);
    reset = 1'b0;
    #1;
    check_eq("t5_rst_tx", tx0, 1);
    check_eq("t5_rst_busy", busy0, 0);
    check_eq("t5_rst_read_en", if0.fifo_read_en, 0);
    check_eq("t5_rst_state", st0, ST_IDLE);
    check_eq("t5_rst_frame_count", fc0, 0);
    void'(exp_q.pop_front());
    exp_frames = 16'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check_eq("t5_after_state", st0, ST_IDLE);
    check_eq("t5_after_tx", tx0, 1);
    check_eq("t5_no_repop", rd0 - rd_before, 1);
    push_byte(8'h5A);
    score_frame("t5", gap);
    @(negedge clock);
    check_eq("t5_frame_count", fc0, exp_frames);

    // frame counter wrap
    force u_dut.frame_count_q = 16'hFFFF;
    @(negedge clock);
    release u_dut.frame_count_q;
    @(negedge clock);
    check_eq("t6_preload", fc0, 16'hFFFF);
    exp_frames = 16'hFFFF;
    push_byte(8'hC3);
    score_frame("t6", gap);
    @(negedge clock);
    check_eq("t6_wrap", fc0, exp_frames);

    // final report
    check_eq("pop_while_empty", pop_viol, 0);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
